// File: rtl/clb_config_loader.sv
// clb_config_loader
//   Serial configuration loader for a row of NUM_CLB logic blocks. A frame is
//   N = NUM_CLB*PROG_W data bits, MSB-first, followed by one even-parity bit.
//   Bits collect in a shadow register. prog_bus is loaded from the shadow only
//   when the parity check passes, so a partial frame is never visible.
//
// Ports
//   clb_clk    sole clock, rising edge
//   rst        asynchronous active-low reset
//   cfg_start  single-cycle frame request (honoured in IDLE/DONE/ERROR only)
//   cfg_bit    serial data
//   cfg_valid  cfg_bit qualifier
//   cfg_ready  loader accepts a bit this cycle (SHIFT or PARITY)
//   prog_bus   committed configuration; slice [k*PROG_W +: PROG_W] -> CLB k
//   cfg_busy   frame in progress (always equal to cfg_ready)
//   cfg_done   last frame committed
//   cfg_err    last frame failed parity
//   dbg_state  current FSM state (IDLE=0 SHIFT=1 PARITY=2 DONE=3 ERROR=4)
//
// Handshake: a bit transfers on a rising edge where cfg_valid && cfg_ready.
// cfg_ready does not depend on cfg_valid. Cycles with cfg_valid low cause no
// state change.
module clb_config_loader #(
  parameter int NUM_CLB = 4,
  parameter int PROG_W  = 17
) (
  input  logic                      clb_clk,
  input  logic                      rst,
  input  logic                      cfg_start,
  input  logic                      cfg_bit,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  output logic [NUM_CLB*PROG_W-1:0] prog_bus,
  output logic                      cfg_busy,
  output logic                      cfg_done,
  output logic                      cfg_err,
  output logic [2:0]                dbg_state
);

  localparam int N  = NUM_CLB * PROG_W;
  // Counter counts 0..N-1 in SHIFT. Sizing for N+1 values guarantees no wrap.
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    PARITY = 3'd2,
    DONE   = 3'd3,
    ERROR  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    shadow_q;
  logic [N-1:0]    prog_q;
  logic            par_q;      // running XOR of the data bits received so far
  logic            done_q, err_q;

  logic            start_frame, shift_en, commit, fail;

  // Next-state logic and datapath strobes
  always_comb begin
    state_d     = state_q;
    cfg_ready   = 1'b0;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    commit      = 1'b0;
    fail        = 1'b0;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (cfg_start) begin
          start_frame = 1'b1;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          shift_en = 1'b1;
          if (cnt_q == LAST) state_d = PARITY;
        end
      end
      PARITY: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          // With even parity, the XOR of the data bits and the parity bit is zero.
          if (par_q ^ cfg_bit) begin
            fail    = 1'b1;
            state_d = ERROR;
          end else begin
            commit  = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clb_clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clb_clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      prog_q   <= '0;
      par_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (start_frame) begin
        cnt_q    <= '0;
        shadow_q <= '0;
        par_q    <= 1'b0;
        done_q   <= 1'b0;
        err_q    <= 1'b0;
      end
      if (shift_en) begin
        shadow_q <= {shadow_q[N-2:0], cfg_bit};
        cnt_q    <= cnt_q + CW'(1);
        par_q    <= par_q ^ cfg_bit;
      end
      if (commit) begin
        prog_q <= shadow_q;
        done_q <= 1'b1;
      end
      if (fail) begin
        err_q <= 1'b1;
      end
    end
  end

  assign cfg_busy  = cfg_ready;
  assign prog_bus  = prog_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_clb_config_loader.sv
module tb_clb_config_loader;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instance 1: NUM_CLB=1 (17-bit frame)
  logic        s1, b1, v1;
  logic        rdy1, busy1, done1, err1;
  logic [16:0] prog1;
  logic [2:0]  st1;

  // Instance 2: NUM_CLB=2 (34-bit frame)
  logic        s2, b2, v2;
  logic        rdy2, busy2, done2, err2;
  logic [33:0] prog2;
  logic [2:0]  st2;

  clb_config_loader #(.NUM_CLB(1), .PROG_W(17)) u_dut1 (
    .clb_clk  (clk),
    .rst      (rst),
    .cfg_start(s1),
    .cfg_bit  (b1),
    .cfg_valid(v1),
    .cfg_ready(rdy1),
    .prog_bus (prog1),
    .cfg_busy (busy1),
    .cfg_done (done1),
    .cfg_err  (err1),
    .dbg_state(st1)
  );

  clb_config_loader #(.NUM_CLB(2), .PROG_W(17)) u_dut2 (
    .clb_clk  (clk),
    .rst      (rst),
    .cfg_start(s2),
    .cfg_bit  (b2),
    .cfg_valid(v2),
    .cfg_ready(rdy2),
    .prog_bus (prog2),
    .cfg_busy (busy2),
    .cfg_done (done2),
    .cfg_err  (err2),
    .dbg_state(st2)
  );

  localparam logic [2:0] S_IDLE = 3'd0, S_SHIFT = 3'd1, S_PARITY = 3'd2,
                         S_DONE = 3'd3, S_ERROR = 3'd4;

  // ---------------- scoreboard counters ----------------
  int n_total  = 0;
  int n_passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  // All drivers start and end #1 after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int sel);
    if (sel == 1) s1 = 1'b1; else s2 = 1'b1;
    step();
    s1 = 1'b0;
    s2 = 1'b0;
  endtask

  task automatic send_bit(input int sel, input logic b);
    if (sel == 1) begin v1 = 1'b1; b1 = b; end
    else          begin v2 = 1'b1; b2 = b; end
    step();
    v1 = 1'b0;
    v2 = 1'b0;
  endtask

  task automatic send_word17(input logic [16:0] w);
    for (int i = 16; i >= 0; i--) send_bit(1, w[i]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [16:0] w17;
    logic [33:0] w34;
    rst = 1'b0;
    s1 = 1'b0; b1 = 1'b0; v1 = 1'b0;
    s2 = 1'b0; b2 = 1'b0; v2 = 1'b0;
    #1;
    // Reset state
    chk("rst_prog1",  {47'd0, prog1}, 64'd0);
    chk("rst_ready1", {63'd0, rdy1},  64'd0);
    chk("rst_busy1",  {63'd0, busy1}, 64'd0);
    chk("rst_done1",  {63'd0, done1}, 64'd0);
    chk("rst_err1",   {63'd0, err1},  64'd0);
    chk("rst_state1", {61'd0, st1},   {61'd0, S_IDLE});
    chk("rst_prog2",  {30'd0, prog2}, 64'd0);
    chk("rst_state2", {61'd0, st2},   {61'd0, S_IDLE});
    step();
    step();
    rst = 1'b1;
    step();
    chk("idle_after_release", {61'd0, st1}, {61'd0, S_IDLE});

    // Frame 17'h1FFFE: sixteen ones, so the even-parity bit is 0
    pulse_start(1);
    chk("start_state", {61'd0, st1},   {61'd0, S_SHIFT});
    chk("start_ready", {63'd0, rdy1},  64'd1);
    chk("start_busy",  {63'd0, busy1}, 64'd1);
    send_word17(17'h1FFFE);
    chk("pre_par_state", {61'd0, st1}, {61'd0, S_PARITY});
    chk("pre_par_prog",  {47'd0, prog1}, 64'd0);
    // Parity bit 0. cfg_valid stays high afterwards.
    v1 = 1'b1; b1 = 1'b0;
    step();
    chk("commit_prog",  {47'd0, prog1}, 64'h1FFFE);
    chk("commit_done",  {63'd0, done1}, 64'd1);
    chk("commit_err",   {63'd0, err1},  64'd0);
    chk("commit_state", {61'd0, st1},   {61'd0, S_DONE});
    chk("commit_ready", {63'd0, rdy1},  64'd0);
    // Valid held with ones after parity: nothing may be accepted
    b1 = 1'b1;
    repeat (4) step();
    chk("hold_prog",  {47'd0, prog1}, 64'h1FFFE);
    chk("hold_ready", {63'd0, rdy1},  64'd0);
    chk("hold_state", {61'd0, st1},   {61'd0, S_DONE});
    v1 = 1'b0;

    // Frame 17'h00001 has one set bit, so parity 0 is wrong
    pulse_start(1);
    chk("restart_done_clr", {63'd0, done1}, 64'd0);
    send_word17(17'h00001);
    send_bit(1, 1'b0);
    chk("bad_err",   {63'd0, err1},  64'd1);
    chk("bad_done",  {63'd0, done1}, 64'd0);
    chk("bad_prog",  {47'd0, prog1}, 64'h1FFFE);
    chk("bad_state", {61'd0, st1},   {61'd0, S_ERROR});

    // Frame 17'h0A5C3 (eight ones, parity 0). cfg_start pulses inside the frame.
    pulse_start(1);
    chk("restart_err_clr", {63'd0, err1}, 64'd0);
    w17 = 17'h0A5C3;
    for (int i = 16; i >= 0; i--) begin
      if (i == 10) s1 = 1'b1;
      if (i == 5) begin
        s1 = 1'b1;          // start with valid low (gap cycle)
        step();
        s1 = 1'b0;
      end
      send_bit(1, w17[i]);
      s1 = 1'b0;
    end
    chk("ign_start_state", {61'd0, st1}, {61'd0, S_PARITY});
    s1 = 1'b1;
    send_bit(1, 1'b0);
    s1 = 1'b0;
    chk("ign_start_done",  {63'd0, done1}, 64'd1);
    chk("ign_start_prog",  {47'd0, prog1}, 64'h0A5C3);
    chk("ign_start_final", {61'd0, st1},   {61'd0, S_DONE});

    // NUM_CLB=2 frame 34'h2DEADBEEF (25 ones -> parity 1), random valid gaps
    w34 = 34'h2DEADBEEF;
    pulse_start(2);
    for (int i = 33; i >= 0; i--) begin
      repeat ($urandom_range(0, 1)) step();
      send_bit(2, w34[i]);
    end
    chk("n2_pre_par_state", {61'd0, st2}, {61'd0, S_PARITY});
    repeat ($urandom_range(0, 2)) step();
    send_bit(2, 1'b1);
    chk("n2_prog",  {30'd0, prog2}, 64'h2DEADBEEF);
    chk("n2_done",  {63'd0, done2}, 64'd1);
    chk("n2_err",   {63'd0, err2},  64'd0);

    // Asynchronous reset after ten data bits
    pulse_start(1);
    for (int i = 0; i < 10; i++) send_bit(1, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_prog",  {47'd0, prog1}, 64'd0);
    chk("arst_ready", {63'd0, rdy1},  64'd0);
    chk("arst_busy",  {63'd0, busy1}, 64'd0);
    chk("arst_done",  {63'd0, done1}, 64'd0);
    chk("arst_err",   {63'd0, err1},  64'd0);
    chk("arst_state", {61'd0, st1},   {61'd0, S_IDLE});
    chk("arst_prog2", {30'd0, prog2}, 64'd0);
    step();
    rst = 1'b1;
    // Twenty valid bits without a start must be ignored
    for (int i = 0; i < 20; i++) send_bit(1, 1'(i % 2));
    chk("nostart_state", {61'd0, st1},   {61'd0, S_IDLE});
    chk("nostart_prog",  {47'd0, prog1}, 64'd0);
    chk("nostart_ready", {63'd0, rdy1},  64'd0);
    chk("nostart_done",  {63'd0, done1}, 64'd0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
